// File: rtl/ieeedrv_pkg.sv
// Purpose: shared types and widths for the SD-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ieeedrv_pkg;

  localparam int LBA_W = 32;
  localparam int BLK_W = 6;

  typedef enum logic [2:0] {
    DRAIN = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    XFER  = 3'd3,
    GAP   = 3'd4
  } ieeedrv_sdarb_state_t;

  // Command captured from the winning requester at grant time.
  typedef struct packed {
    logic [LBA_W-1:0] lba;
    logic [BLK_W-1:0] blk_cnt;
  } ieeedrv_sd_cmd_t;

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Purpose: combinational round-robin picker over a pending vector.
// Latency: zero (pure combinational).
// Backpressure: none; valid/index follow the inputs.
// Ports: pending (one bit per requester), last_owner (index of previous owner),
//        valid (any pending), index (first pending at or after last_owner+1, wrapping).
module ieeedrv_rr_pick
  import ieeedrv_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] last_owner,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0]  start;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                sum;

  always_comb begin
    start = (last_owner == IDX_W'(NREQ - 1)) ? '0 : last_owner + IDX_W'(1);
    // Rotate so bit 0 of rot is the requester whose turn comes first.
    dbl   = {pending, pending} >> start;
    rot   = dbl[NREQ-1:0];
    valid = |pending;
    index = '0;
    sum   = 0;
    // Scan from the far end so the lowest rotated position wins.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(start) + j;
        if (sum >= NREQ) sum = sum - NREQ;
        index = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Purpose: round-robin arbiter sharing one SD host port among NREQ track-buffer requesters.
// Latency: sd_rd/sd_wr rise 1 cycle after selection in IDLE; ack/buff_wr routed with zero latency.
// Backpressure: requester holds its rd/wr level until served; host ack paces the transfer, timeout abandons.
// Ports: clk_sys/reset (sync, active high); req_lba/req_blk_cnt/req_rd/req_wr in and req_ack/req_buff_wr out
//        per requester; sd_lba/sd_blk_cnt/sd_rd/sd_wr to host, sd_ack/sd_buff_wr from host;
//        grant (one-hot owner), busy (not IDLE), timeout (one-cycle abandon pulse).
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TMO_W = 20
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ*LBA_W-1:0] req_lba,
  input  logic [NREQ*BLK_W-1:0] req_blk_cnt,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       req_buff_wr,
  output logic [LBA_W-1:0]      sd_lba,
  output logic [BLK_W-1:0]      sd_blk_cnt,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic                  sd_buff_wr,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  timeout
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Counter value in the last ISSUE cycle before the count would hit all-ones.
  localparam logic [TMO_W-1:0] TMO_PRE = ~TMO_W'(1);

  ieeedrv_sdarb_state_t state_q, state_d;
  ieeedrv_sd_cmd_t      cmd_q;
  logic [NREQ-1:0]      grant_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     last_owner_q;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [NREQ-1:0]      pending;
  logic [NREQ-1:0]      pick_oh;
  logic                 wr_sel;
  logic                 rd_q;
  logic                 wr_q;
  logic                 old_ack_q;
  logic                 timeout_q;
  logic [TMO_W-1:0]     cnt_q;
  logic                 owner_live;
  logic                 ack_fall;
  logic                 tmo_hit;

  logic [LBA_W-1:0] lba_arr [NREQ];
  logic [BLK_W-1:0] blk_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign lba_arr[g] = req_lba[g*LBA_W +: LBA_W];
    assign blk_arr[g] = req_blk_cnt[g*BLK_W +: BLK_W];
  end

  assign pending    = req_rd | req_wr;
  assign pick_oh    = NREQ'(1) << pick_idx;
  assign wr_sel     = |(req_wr & pick_oh);   // write wins when both levels are high
  assign owner_live = |(pending & grant_q);
  assign ack_fall   = old_ack_q & ~sd_ack;
  assign tmo_hit    = (cnt_q == TMO_PRE);

  ieeedrv_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending    (pending),
    .last_owner (last_owner_q),
    .valid      (pick_vld),
    .index      (pick_idx)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= DRAIN;
    else       state_q <= state_d;
  end

  // Next-state logic. In ISSUE an ack beats an abort, and an abort beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN: if (!sd_ack) state_d = IDLE;
      IDLE:  if (pick_vld) state_d = ISSUE;
      ISSUE: begin
        if (sd_ack)           state_d = XFER;
        else if (!owner_live) state_d = IDLE;
        else if (tmo_hit)     state_d = IDLE;
      end
      XFER:  if (ack_fall) state_d = GAP;
      GAP:   state_d = IDLE;
      default: state_d = DRAIN;
    endcase
  end

  // Command latch, grant, round-robin pointer and timeout counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cmd_q        <= '0;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NREQ - 1);
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      old_ack_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      old_ack_q <= sd_ack;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            cmd_q.lba     <= lba_arr[pick_idx];
            cmd_q.blk_cnt <= blk_arr[pick_idx];
            grant_q       <= pick_oh;
            owner_q       <= pick_idx;
            wr_q          <= wr_sel;
            rd_q          <= ~wr_sel;
            cnt_q         <= '0;
          end
        end
        ISSUE: begin
          if (cnt_q != '1) cnt_q <= cnt_q + TMO_W'(1);
          if (sd_ack) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
          end else if (!owner_live) begin
            // Abort: requester gave up; its turn is not consumed.
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= '0;
          end else if (tmo_hit) begin
            timeout_q    <= 1'b1;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            grant_q      <= '0;
            last_owner_q <= owner_q;
          end
        end
        GAP: begin
          grant_q      <= '0;
          last_owner_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs. The request is masked by sd_ack so it drops in the ack cycle itself.
  always_comb begin
    busy        = (state_q != IDLE);
    sd_rd       = rd_q & ~sd_ack;
    sd_wr       = wr_q & ~sd_ack;
    grant       = grant_q;
    req_ack     = grant_q & {NREQ{sd_ack}};
    req_buff_wr = grant_q & {NREQ{sd_buff_wr}};
    sd_lba      = cmd_q.lba;
    sd_blk_cnt  = cmd_q.blk_cnt;
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Purpose: self-checking bench for ieeedrv_sd_arb against a behavioural reference model.
// Latency: model predicts every output every cycle, sampled mid-cycle.
// Backpressure: bench plays the SD host with programmable ack delay and length.
module tb_ieeedrv_sd_arb;

  localparam int NREQ    = 2;
  localparam int TMO_W   = 4;
  localparam int TMO_CYC = (1 << TMO_W) - 1;   // ISSUE cycles before abandoning

  localparam int PH_DRAIN = 0;
  localparam int PH_IDLE  = 1;
  localparam int PH_ISSUE = 2;
  localparam int PH_XFER  = 3;
  localparam int PH_GAP   = 4;

  logic                 clk_sys = 1'b0;
  logic                 reset;
  logic [NREQ*32-1:0]   req_lba;
  logic [NREQ*6-1:0]    req_blk_cnt;
  logic [NREQ-1:0]      req_rd, req_wr, req_ack, req_buff_wr, grant;
  logic [31:0]          sd_lba;
  logic [5:0]           sd_blk_cnt;
  logic                 sd_rd, sd_wr, sd_ack, sd_buff_wr, busy, timeout;

  always #5 clk_sys = ~clk_sys;

  ieeedrv_sd_arb #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req_lba     (req_lba),
    .req_blk_cnt (req_blk_cnt),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_ack     (req_ack),
    .req_buff_wr (req_buff_wr),
    .sd_lba      (sd_lba),
    .sd_blk_cnt  (sd_blk_cnt),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .grant       (grant),
    .busy        (busy),
    .timeout     (timeout)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: transaction phase, owner, round-robin pointer, latched command.
  bit          live = 1'b0;
  int          ph = PH_DRAIN;
  int          own = 0;
  int          last = NREQ - 1;
  int          n_iss = 0;
  logic [31:0] m_lba = '0;
  logic [5:0]  m_blk = '0;
  bit          m_wr = 1'b0;
  bit          m_tmo = 1'b0;
  bit          m_old = 1'b0;

  // Host model state.
  bit h_ack = 1'b0;
  int h_dly = -1;
  int h_hold = 0;
  int dmin = 3, dmax = 3, hmin = 10, hmax = 10;

  // One clock: check outputs mid-cycle, advance the model at the edge, then react as host.
  task automatic tick();
    logic [NREQ-1:0] g;
    bit              prev;
    int              i;
    #3;
    if (live) begin
      g = (ph >= PH_ISSUE) ? (NREQ'(1) << own) : '0;
      chk("grant",   grant, g);
      chk("sd_rd",   sd_rd, (ph == PH_ISSUE) && !m_wr && !sd_ack);
      chk("sd_wr",   sd_wr, (ph == PH_ISSUE) && m_wr && !sd_ack);
      chk("busy",    busy, ph != PH_IDLE);
      chk("timeout", timeout, m_tmo);
      chk("sd_lba",  sd_lba, m_lba);
      chk("sd_blk",  sd_blk_cnt, m_blk);
      chk("req_ack", req_ack, sd_ack ? g : '0);
      chk("buff_wr", req_buff_wr, sd_buff_wr ? g : '0);
    end
    @(posedge clk_sys);
    #1;
    if (reset) begin
      live  = 1'b1;
      ph    = PH_DRAIN;
      last  = NREQ - 1;
      own   = 0;
      m_lba = '0;
      m_blk = '0;
      m_tmo = 1'b0;
      m_old = 1'b0;
    end else begin
      m_tmo = 1'b0;
      prev  = m_old;
      m_old = sd_ack;
      case (ph)
        PH_DRAIN: if (!sd_ack) ph = PH_IDLE;
        PH_IDLE: begin
          for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (req_rd[i] || req_wr[i]) begin
              own   = i;
              m_lba = req_lba[i*32 +: 32];
              m_blk = req_blk_cnt[i*6 +: 6];
              m_wr  = req_wr[i];
              n_iss = 0;
              ph    = PH_ISSUE;
              break;
            end
          end
        end
        PH_ISSUE: begin
          n_iss++;
          if (sd_ack) ph = PH_XFER;
          else if (!(req_rd[own] || req_wr[own])) ph = PH_IDLE;
          else if (n_iss == TMO_CYC) begin
            m_tmo = 1'b1;
            last  = own;
            ph    = PH_IDLE;
          end
        end
        PH_XFER: if (prev && !sd_ack) ph = PH_GAP;
        PH_GAP: begin
          last = own;
          ph   = PH_IDLE;
        end
        default: ;
      endcase
    end
    // Host: ack after a delay once a command is issued, hold it for a while.
    if (h_ack) begin
      h_hold--;
      if (h_hold <= 0) begin
        h_ack  = 1'b0;
        sd_ack = 1'b0;
      end
    end else if (ph == PH_ISSUE) begin
      if (h_dly < 0) h_dly = $urandom_range(dmax, dmin);
      if (h_dly == 0) begin
        h_ack  = 1'b1;
        sd_ack = 1'b1;
        h_hold = $urandom_range(hmax, hmin);
        h_dly  = -1;
      end else begin
        h_dly--;
      end
    end else begin
      h_dly = -1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  bit found;

  initial begin
    reset       = 1'b1;
    req_lba     = '0;
    req_blk_cnt = '0;
    req_rd      = '0;
    req_wr      = '0;
    sd_ack      = 1'b0;
    sd_buff_wr  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Single read from requester 0, host acks after a few cycles for 10 cycles.
    req_lba[31:0]    = 32'h1D;
    req_blk_cnt[5:0] = 6'd28;
    req_lba[63:32]   = 32'hABCD0001;
    req_blk_cnt[11:6] = 6'd5;
    req_rd = 2'b01;
    for (int c = 0; c < 30; c++) begin
      sd_buff_wr = 1'($urandom_range(0, 1));
      tick();
    end
    req_rd = 2'b00;
    repeat (5) tick();

    // Both request together after reset; requester 1 asks for read and write.
    do_reset();
    req_rd = 2'b11;
    req_wr = 2'b10;
    repeat (90) tick();

    // Host never acks in time: every command is abandoned and the turn rotates.
    dmin = 40; dmax = 40;
    repeat (70) tick();
    req_rd = 2'b00;
    req_wr = 2'b00;
    dmin = 3; dmax = 3;
    repeat (20) tick();

    // Reset in the middle of a transfer while the host keeps acking.
    req_rd = 2'b01;
    dmin = 2; dmax = 2; hmin = 20; hmax = 20;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (ph == PH_XFER) found = 1'b1;
    end
    chk("reach_xfer", found, 1'b1);
    if (found) begin
      reset  = 1'b1;
      h_hold = 6;
      tick();
      reset = 1'b0;
      req_rd = 2'b11;
      repeat (15) tick();
    end

    // Randomised traffic with occasional resets, some landing mid-transfer.
    dmin = 0; dmax = 18; hmin = 1; hmax = 10;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req_rd[i] = ~req_rd[i];
        if ($urandom_range(0, 15) == 0) req_wr[i] = ~req_wr[i];
        if ($urandom_range(0, 3) == 0) begin
          req_lba[i*32 +: 32]    = $urandom;
          req_blk_cnt[i*6 +: 6]  = 6'($urandom);
        end
      end
      sd_buff_wr = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 499) == 0) ||
              ((ph == PH_XFER) && ($urandom_range(0, 39) == 0));
      if (reset && h_ack) h_hold = 6;
      tick();
    end
    reset = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
